threshold_calib: RTL and testbench

- Parametrised successor to the fixed 784-input max-and-divide-by-3 threshold unit.
- During calibration it requests STEPS samples from the input spike generator and popcounts each M-bit spike vector in a pipelined adder tree.
- It accumulates either the peak count (MAX mode) or the total count (SUM mode), scales the result by a runtime fixed-point multiplier, and presents the neuron threshold with a valid pulse.
- Sits between the input spike generator and the neuron array threshold registers.

---
 rtl/threshold_calib.sv | 242 ++++++++++++++++++++++++
 tb/tb_threshold_calib.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_calib.sv
`default_nettype none
// ============================================================================
// Module  : threshold_calib
// Brief   : Popcounts STEPS spike vectors, keeps the peak (MAX) or the
//           saturating total (SUM), scales by a fixed-point multiplier.
// Revision: 1.0
// ============================================================================
module threshold_calib #(
    parameter int M     = 784,
    parameter int W     = 24,
    parameter int STEPS = 200,
    parameter int GROUP = 32,
    parameter int FRAC  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         mode,
    input  logic [15:0]  scale_mul,
    input  logic [M-1:0] ips_gen_out,
    input  logic         ips_valid,
    output logic         start_ips_gen,
    output logic         next_ips_gen,
    output logic         busy,
    output logic         maxer_valid,
    output logic [W-1:0] threshold,
    output logic [15:0]  peak_step
);
    localparam int             C_NG    = (M + GROUP - 1) / GROUP;
    localparam int             C_PW    = C_NG * GROUP;
    localparam int             C_GW    = $clog2(GROUP + 1);
    localparam int             C_CW    = $clog2(M + 1);
    localparam logic [16:0]    C_STEPS = 17'(STEPS);
    localparam logic [W-1:0]   C_SAT   = {W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_SCALE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [15:0]     scale_q, scale_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [15:0]     req_cnt_q, req_cnt_d;
    logic [15:0]     acc_cnt_q, acc_cnt_d;
    logic [15:0]     smp_cnt_q, smp_cnt_d;
    logic [15:0]     pk_q, pk_d;
    logic [M-1:0]    s0_vec_q, s0_vec_d;
    logic            s0_vld_q, s0_vld_d;
    logic [C_GW-1:0] s1_cnt_q [C_NG];
    logic [C_GW-1:0] s1_cnt_d [C_NG];
    logic            s1_vld_q, s1_vld_d;
    logic [C_CW-1:0] s2_cnt_q, s2_cnt_d;
    logic            s2_vld_q, s2_vld_d;
    logic [W-1:0]    res_q, res_d;
    logic            start_ips_gen_q, start_ips_gen_d;
    logic            next_ips_gen_q, next_ips_gen_d;
    logic            busy_q, busy_d;
    logic            maxer_valid_q, maxer_valid_d;
    logic [W-1:0]    threshold_q, threshold_d;
    logic [15:0]     peak_step_q, peak_step_d;

    logic [C_PW-1:0] w_pad;
    logic            w_accept;
    logic [W-1:0]    w_cnt_ext;
    logic [W:0]      w_sum;
    logic [W+15:0]   w_prod;
    logic [W+15:0]   w_shift;

    assign w_pad = C_PW'(s0_vec_q);

    // Two-level adder tree: per-group counts, then their total.
    always_comb begin
        for (int g = 0; g < C_NG; g++) begin
            s1_cnt_d[g] = '0;
            for (int b = 0; b < GROUP; b++) begin
                s1_cnt_d[g] = s1_cnt_d[g] + C_GW'(w_pad[g*GROUP + b]);
            end
        end
        s2_cnt_d = '0;
        for (int g = 0; g < C_NG; g++) begin
            s2_cnt_d = s2_cnt_d + C_CW'(s1_cnt_q[g]);
        end
    end

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        scale_d         = scale_q;
        acc_d           = acc_q;
        req_cnt_d       = req_cnt_q;
        acc_cnt_d       = acc_cnt_q;
        smp_cnt_d       = smp_cnt_q;
        pk_d            = pk_q;
        s0_vec_d        = s0_vec_q;
        res_d           = res_q;
        threshold_d     = threshold_q;
        peak_step_d     = peak_step_q;
        start_ips_gen_d = 1'b0;
        next_ips_gen_d  = 1'b0;
        maxer_valid_d   = 1'b0;

        w_accept  = (state_q == S_RUN) && ips_valid && ({1'b0, acc_cnt_q} < C_STEPS);
        w_cnt_ext = W'(s2_cnt_q);
        w_sum     = {1'b0, acc_q} + {1'b0, w_cnt_ext};
        w_prod    = (W+16)'(acc_q) * (W+16)'(scale_q);
        w_shift   = w_prod >> FRAC;

        if (w_accept) begin
            s0_vec_d  = ips_gen_out;
            acc_cnt_d = acc_cnt_q + 16'd1;
        end
        s0_vld_d = w_accept;
        s1_vld_d = s0_vld_q;
        s2_vld_d = s1_vld_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d         = S_LAUNCH;
                    mode_d          = mode;
                    scale_d         = scale_mul;
                    acc_d           = '0;
                    req_cnt_d       = '0;
                    acc_cnt_d       = '0;
                    smp_cnt_d       = '0;
                    pk_d            = '0;
                    start_ips_gen_d = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d        = S_RUN;
                next_ips_gen_d = 1'b1;
            end
            S_RUN: begin
                req_cnt_d      = req_cnt_q + {15'd0, next_ips_gen_q};
                next_ips_gen_d = ({1'b0, req_cnt_d} < C_STEPS);
                if (s2_vld_q) begin
                    smp_cnt_d = smp_cnt_q + 16'd1;
                    if (mode_q) begin
                        acc_d = w_sum[W] ? C_SAT : w_sum[W-1:0];
                    end else if (w_cnt_ext > acc_q) begin
                        acc_d = w_cnt_ext;
                        pk_d  = smp_cnt_q;
                    end
                    if (({1'b0, smp_cnt_q} + 17'd1) == C_STEPS) begin
                        state_d        = S_SCALE;
                        next_ips_gen_d = 1'b0;
                    end
                end
            end
            S_SCALE: begin
                res_d   = (|w_shift[W+15:W]) ? C_SAT : w_shift[W-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                threshold_d   = res_q;
                peak_step_d   = mode_q ? 16'd0 : pk_q;
                maxer_valid_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards the run without touching the published result.
        if (abort && (state_q != S_IDLE)) begin
            state_d         = S_IDLE;
            next_ips_gen_d  = 1'b0;
            start_ips_gen_d = 1'b0;
            s0_vld_d        = 1'b0;
            s1_vld_d        = 1'b0;
            s2_vld_d        = 1'b0;
            threshold_d     = threshold_q;
            peak_step_d     = peak_step_q;
            maxer_valid_d   = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            mode_q          <= 1'b0;
            scale_q         <= '0;
            acc_q           <= '0;
            req_cnt_q       <= '0;
            acc_cnt_q       <= '0;
            smp_cnt_q       <= '0;
            pk_q            <= '0;
            s0_vec_q        <= '0;
            s0_vld_q        <= 1'b0;
            for (int g = 0; g < C_NG; g++) s1_cnt_q[g] <= '0;
            s1_vld_q        <= 1'b0;
            s2_cnt_q        <= '0;
            s2_vld_q        <= 1'b0;
            res_q           <= '0;
            start_ips_gen_q <= 1'b0;
            next_ips_gen_q  <= 1'b0;
            busy_q          <= 1'b0;
            maxer_valid_q   <= 1'b0;
            threshold_q     <= '0;
            peak_step_q     <= '0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            scale_q         <= scale_d;
            acc_q           <= acc_d;
            req_cnt_q       <= req_cnt_d;
            acc_cnt_q       <= acc_cnt_d;
            smp_cnt_q       <= smp_cnt_d;
            pk_q            <= pk_d;
            s0_vec_q        <= s0_vec_d;
            s0_vld_q        <= s0_vld_d;
            for (int g = 0; g < C_NG; g++) s1_cnt_q[g] <= s1_cnt_d[g];
            s1_vld_q        <= s1_vld_d;
            s2_cnt_q        <= s2_cnt_d;
            s2_vld_q        <= s2_vld_d;
            res_q           <= res_d;
            start_ips_gen_q <= start_ips_gen_d;
            next_ips_gen_q  <= next_ips_gen_d;
            busy_q          <= busy_d;
            maxer_valid_q   <= maxer_valid_d;
            threshold_q     <= threshold_d;
            peak_step_q     <= peak_step_d;
        end
    end

    assign start_ips_gen = start_ips_gen_q;
    assign next_ips_gen  = next_ips_gen_q;
    assign busy          = busy_q;
    assign maxer_valid   = maxer_valid_q;
    assign threshold     = threshold_q;
    assign peak_step     = peak_step_q;

endmodule
`default_nettype wire

// File: tb/tb_threshold_calib.sv
`default_nettype none
// ============================================================================
// Module  : tb_threshold_calib
// Brief   : Randomised bench for threshold_calib against an arithmetic model.
// Revision: 1.0
// ============================================================================
module tb_threshold_calib;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         b_start = 1'b0;
    logic         s_start = 1'b0;
    logic         abort = 1'b0;
    logic         mode = 1'b0;
    logic [15:0]  scale_mul = '0;
    logic [783:0] ips_gen_out = '0;
    logic         ips_valid = 1'b0;

    logic         b_sip, b_nip, b_busy, b_mv;
    logic [23:0]  b_thr;
    logic [15:0]  b_pk;
    logic         s_sip, s_nip, s_busy, s_mv;
    logic [11:0]  s_thr;
    logic [15:0]  s_pk;

    logic         sel = 1'b1;
    logic         o_sip, o_nip, o_busy, o_mv;
    logic [23:0]  o_thr;
    logic [15:0]  o_pk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_next, n_sip, n_mv;
    logic last_mv;

    always #5 clk = ~clk;

    threshold_calib u_big (
        .clk(clk), .rst(rst), .start(b_start), .abort(abort), .mode(mode),
        .scale_mul(scale_mul), .ips_gen_out(ips_gen_out), .ips_valid(ips_valid),
        .start_ips_gen(b_sip), .next_ips_gen(b_nip), .busy(b_busy),
        .maxer_valid(b_mv), .threshold(b_thr), .peak_step(b_pk)
    );

    threshold_calib #(.M(784), .W(12), .STEPS(8), .GROUP(32), .FRAC(16)) u_sml (
        .clk(clk), .rst(rst), .start(s_start), .abort(abort), .mode(mode),
        .scale_mul(scale_mul), .ips_gen_out(ips_gen_out), .ips_valid(ips_valid),
        .start_ips_gen(s_sip), .next_ips_gen(s_nip), .busy(s_busy),
        .maxer_valid(s_mv), .threshold(s_thr), .peak_step(s_pk)
    );

    assign o_sip  = sel ? b_sip  : s_sip;
    assign o_nip  = sel ? b_nip  : s_nip;
    assign o_busy = sel ? b_busy : s_busy;
    assign o_mv   = sel ? b_mv   : s_mv;
    assign o_thr  = sel ? b_thr  : {12'd0, s_thr};
    assign o_pk   = sel ? b_pk   : s_pk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle; output activity of the selected instance is tallied.
    task automatic tick();
        @(negedge clk);
        if (o_nip) n_next++;
        if (o_sip) n_sip++;
        if (o_mv)  n_mv++;
        last_mv = o_mv;
    endtask

    function automatic logic [783:0] mkvec(input int p);
        logic [783:0] v;
        logic         t;
        int           j;
        v = '0;
        for (int i = 0; i < p; i++) v[i] = 1'b1;
        for (int i = 783; i > 0; i--) begin
            j    = int'($urandom_range(i, 0));
            t    = v[i];
            v[i] = v[j];
            v[j] = t;
        end
        return v;
    endfunction

    function automatic void model(input int cnts[$], input bit md, input int scl,
                                  input int wb, output longint thr, output int pk);
        longint acc;
        longint sat;
        acc = 0;
        pk  = 0;
        sat = (longint'(1) << wb) - 1;
        foreach (cnts[i]) begin
            if (md) begin
                acc = acc + cnts[i];
                if (acc > sat) acc = sat;
            end else if (cnts[i] > acc) begin
                acc = cnts[i];
                pk  = i;
            end
        end
        thr = (acc * scl) >> 16;
        if (thr > sat) thr = sat;
        if (md) pk = 0;
    endfunction

    task automatic run(input bit big, input bit md, input int scl, input int cnts[$],
                       input int gapmax, input bit extra, input int abort_at,
                       input int busy_start_at, input bit rst_scale);
        int          steps;
        int          lat;
        int          pk;
        longint      thr;
        logic [23:0] thr_before;
        logic [15:0] pk_before;
        steps = cnts.size();
        sel   = big;
        #1;
        thr_before = o_thr;
        pk_before  = o_pk;
        n_next = 0; n_sip = 0; n_mv = 0;
        mode      = md;
        scale_mul = 16'(scl);
        if (big) b_start = 1'b1; else s_start = 1'b1;
        tick();
        b_start = 1'b0; s_start = 1'b0;
        check("launch_busy", o_busy, 1);
        tick();
        for (int i = 0; i < steps; i++) begin
            ips_valid = 1'b0;
            repeat ($urandom_range(gapmax, 0)) tick();
            ips_gen_out = mkvec(cnts[i]);
            ips_valid   = 1'b1;
            if (i == busy_start_at) begin
                if (big) b_start = 1'b1; else s_start = 1'b1;
                mode      = ~md;
                scale_mul = 16'($urandom_range(65535, 0));
            end
            tick();
            b_start = 1'b0; s_start = 1'b0;
            if (i == abort_at) begin
                ips_valid = 1'b0;
                abort     = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_busy", o_busy, 0);
                check("abort_next", o_nip, 0);
                repeat (8) tick();
                check("abort_no_mv", n_mv, 0);
                check("abort_thr_held", o_thr, thr_before);
                check("abort_pk_held", o_pk, pk_before);
                return;
            end
        end
        if (rst_scale) begin
            ips_valid = 1'b0;
            repeat (3) tick();
            rst = 1'b1;
            #1;
            check("rst_thr", o_thr, 0);
            check("rst_busy", o_busy, 0);
            check("rst_next", o_nip, 0);
            check("rst_pk", o_pk, 0);
            tick();
            rst = 1'b0;
            repeat (10) tick();
            check("rst_no_mv", n_mv, 0);
            check("rst_thr_after", o_thr, 0);
            return;
        end
        lat = 1;
        while (!last_mv && lat < 40) begin
            ips_valid   = extra ? 1'($urandom_range(1, 0)) : 1'b0;
            ips_gen_out = extra ? '1 : '0;
            tick();
            lat++;
        end
        ips_valid = 1'b0;
        model(cnts, md, scl, big ? 24 : 12, thr, pk);
        check("latency", lat, 6);
        check("threshold", o_thr, 32'(thr));
        check("peak_step", o_pk, 32'(pk));
        repeat (4) tick();
        check("mv_pulses", n_mv, 1);
        check("next_cycles", n_next, steps);
        check("sip_pulses", n_sip, 1);
        check("idle_busy", o_busy, 0);
    endtask

    initial begin
        int q[$];
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 0);
            #1;
            check("rst_thr0", o_thr, 0);
            check("rst_ctl0", {o_sip, o_nip, o_busy, o_mv}, 0);
            check("rst_pk0", o_pk, 0);
        end
        rst = 1'b0;
        tick();

        q = {};
        for (int i = 0; i < 200; i++) q.push_back(10);
        q[57] = 300; q[120] = 300;
        run(1'b1, 1'b0, 21845, q, 0, 1'b0, -1, -1, 1'b0);
        check("t1_thr_99", o_thr, 99);
        check("t1_pk_57", o_pk, 57);

        q = {1, 2, 3, 4, 0, 0, 0, 0};
        run(1'b0, 1'b1, 16384, q, 0, 1'b0, -1, -1, 1'b0);
        check("t2_thr_2", o_thr, 2);

        q = {};
        for (int i = 0; i < 8; i++) q.push_back(784);
        run(1'b0, 1'b1, 65535, q, 0, 1'b0, -1, -1, 1'b0);
        check("t3_thr_sat", o_thr, 4094);

        q = {};
        for (int i = 0; i < 200; i++) q.push_back(int'($urandom_range(60, 0)));
        run(1'b1, 1'b0, int'($urandom_range(65535, 1)), q, 5, 1'b1, -1, 50, 1'b0);

        q = {};
        for (int i = 0; i < 200; i++) q.push_back(int'($urandom_range(784, 0)));
        run(1'b1, 1'b1, int'($urandom_range(65535, 1)), q, 5, 1'b1, -1, 77, 1'b0);

        q = {};
        for (int i = 0; i < 8; i++) q.push_back(int'($urandom_range(784, 0)));
        run(1'b0, 1'b1, int'($urandom_range(65535, 1)), q, 3, 1'b1, -1, 3, 1'b0);

        q = {};
        for (int i = 0; i < 200; i++) q.push_back(0);
        run(1'b1, 1'b0, 40000, q, 1, 1'b0, -1, -1, 1'b0);

        q = {};
        for (int i = 0; i < 200; i++) q.push_back(int'($urandom_range(60, 0)));
        run(1'b1, 1'b0, 30000, q, 2, 1'b0, 100, -1, 1'b0);

        q = {};
        for (int i = 0; i < 200; i++) q.push_back(int'($urandom_range(60, 2)));
        run(1'b1, 1'b0, 65535, q, 2, 1'b0, -1, -1, 1'b0);

        q = {};
        for (int i = 0; i < 200; i++) q.push_back(int'($urandom_range(784, 0)));
        run(1'b1, 1'b1, 50000, q, 1, 1'b0, -1, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
